// File: rtl/rgb_grant_scheduler.sv
// -----------------------------------------------------------------------------
// rgb_grant_scheduler
//
// Purpose
//   Shares one colour output channel between three level-sensitive requesters
//   (Red, Green, Blue). One requester owns the channel at a time for a bounded
//   dwell of HOLD_CYCLES clocks. Every grant is followed by a single all-zero
//   break-before-make cycle. NewColor pulses on the first cycle of a grant
//   whose colour differs from the colour served before it. The block feeds the
//   colour-change FSM and the lamp drivers.
//
// Parameters
//   HOLD_CYCLES  maximum grant dwell in clocks (values below 1 behave as 1)
//   CNT_W        width of the dwell counter; must be able to hold HOLD_CYCLES-1
//
// Ports
//   Clock       in   1      rising-edge clock
//   Reset       in   1      asynchronous, active-high reset
//   Red         in   1      red request (level)
//   Green       in   1      green request (level)
//   Blue        in   1      blue request (level)
//   GrantRed    out  1      red owns the channel
//   GrantGreen  out  1      green owns the channel
//   GrantBlue   out  1      blue owns the channel
//   NewColor    out  1      one-cycle pulse on the first cycle of a new colour
//   Busy        out  1      high while a grant is being held
//   HoldCount   out  CNT_W  dwell cycles remaining after the current one
//
// Configuration macro
//   RGB_SCHED_FIXED_PRIO_EN
//     defined   : fixed priority Red > Green > Blue
//     undefined : round robin starting after the last colour served (default)
//
// All outputs are registered. Grants are one-hot or all zero.
// -----------------------------------------------------------------------------
module rgb_grant_scheduler #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Red,
    input  logic             Green,
    input  logic             Blue,
    output logic             GrantRed,
    output logic             GrantGreen,
    output logic             GrantBlue,
    output logic             NewColor,
    output logic             Busy,
    output logic [CNT_W-1:0] HoldCount
);

    // Dwell clamped to at least one cycle; the counter is loaded with
    // dwell-1 because the first grant cycle is itself part of the dwell.
    localparam int               HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Colours are carried one-hot as {red, green, blue}.
    localparam logic [2:0] C_RED   = 3'b100;
    localparam logic [2:0] C_GREEN = 3'b010;
    localparam logic [2:0] C_BLUE  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

`ifdef RGB_SCHED_FIXED_PRIO_EN
    // Fixed priority: Red beats Green beats Blue regardless of history.
    function automatic logic [2:0] f_pick(input logic [2:0] req);
        logic [2:0] pick;
        pick = 3'b000;
        if (req[2])      pick = C_RED;
        else if (req[1]) pick = C_GREEN;
        else if (req[0]) pick = C_BLUE;
        return pick;
    endfunction
`else
    // Round robin: search R->G->B->R starting at the colour after 'last'.
    // Any value of 'last' other than red/green is treated as blue, which is
    // also the reset value, so Red wins the first arbitration.
    function automatic logic [2:0] f_pick(input logic [2:0] req,
                                          input logic [2:0] last);
        logic [2:0] pick;
        pick = 3'b000;
        case (last)
            C_RED: begin
                if (req[1])      pick = C_GREEN;
                else if (req[0]) pick = C_BLUE;
                else if (req[2]) pick = C_RED;
            end
            C_GREEN: begin
                if (req[0])      pick = C_BLUE;
                else if (req[2]) pick = C_RED;
                else if (req[1]) pick = C_GREEN;
            end
            default: begin
                if (req[2])      pick = C_RED;
                else if (req[1]) pick = C_GREEN;
                else if (req[0]) pick = C_BLUE;
            end
        endcase
        return pick;
    endfunction
`endif

    state_t           r_state;
    logic [2:0]       r_grant;
    logic [2:0]       r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_newcolor;
    logic             r_busy;

    state_t           w_state_nx;
    logic [2:0]       w_grant_nx;
    logic [2:0]       w_last_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_newcolor_nx;
    logic             w_busy_nx;
    logic [2:0]       w_req;
    logic [2:0]       w_pick;
    logic             w_release;

    assign w_req = {Red, Green, Blue};

`ifdef RGB_SCHED_FIXED_PRIO_EN
    assign w_pick = f_pick(w_req);
`else
    assign w_pick = f_pick(w_req, r_last);
`endif

    // Leave HOLD when the owner drops its request or the dwell is used up.
    // Both conditions together still give a single move to GAP.
    assign w_release = ((r_grant & w_req) == 3'b000) || (r_cnt == '0);

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_grant    <= 3'b000;
            r_last     <= C_BLUE;
            r_cnt      <= '0;
            r_newcolor <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_last     <= w_last_nx;
            r_cnt      <= w_cnt_nx;
            r_newcolor <= w_newcolor_nx;
            r_busy     <= w_busy_nx;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        w_state_nx    = r_state;
        w_grant_nx    = r_grant;
        w_last_nx     = r_last;
        w_cnt_nx      = r_cnt;
        w_newcolor_nx = 1'b0;
        w_busy_nx     = r_busy;

        case (r_state)
            // IDLE and GAP arbitrate identically at their closing edge.
            ST_IDLE, ST_GAP: begin
                if (w_req != 3'b000) begin
                    w_state_nx    = ST_HOLD;
                    w_grant_nx    = w_pick;
                    w_cnt_nx      = HOLD_LOAD;
                    w_busy_nx     = 1'b1;
                    w_newcolor_nx = (w_pick != r_last);
                    w_last_nx     = w_pick;
                end else begin
                    w_state_nx = ST_IDLE;
                    w_grant_nx = 3'b000;
                    w_cnt_nx   = '0;
                    w_busy_nx  = 1'b0;
                end
            end

            // Other requests are ignored here: no preemption.
            ST_HOLD: begin
                if (w_release) begin
                    w_state_nx = ST_GAP;
                    w_grant_nx = 3'b000;
                    w_cnt_nx   = '0;
                    w_busy_nx  = 1'b0;
                end else begin
                    w_cnt_nx = r_cnt - CNT_ONE;
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
                w_grant_nx = 3'b000;
                w_cnt_nx   = '0;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    assign GrantRed   = r_grant[2];
    assign GrantGreen = r_grant[1];
    assign GrantBlue  = r_grant[0];
    assign NewColor   = r_newcolor;
    assign Busy       = r_busy;
    assign HoldCount  = r_cnt;

endmodule
